// File: rtl/piso_serializer_pkg.sv
// Shared definitions for the serial-link blocks: FSM encodings and a
// constant clog2 used to size counters from elaboration-time parameters.
package piso_serializer_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v = value - 1;
        while (v > 0) begin
            result = result + 1;
            v = v >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/piso_serializer_bit_counter.sv
// Bit position counter for the serializer; saturates at WIDTH-1 and flags
// both the terminal position and the one before it.
module bit_counter
    import piso_serializer_pkg::*;
#(
    parameter int WIDTH = 10,
    parameter int CNT_W = clog2(WIDTH + 1)
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic inc,
    output logic tc,
    output logic pre_tc
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (inc && !tc) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tc     = (cnt == CNT_W'(WIDTH - 1));
    assign pre_tc = (cnt == CNT_W'(WIDTH - 2));

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in serial-out transmitter: LSB-first bit stream with a per-bit
// strobe, valid/ready word intake and a downstream hold.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | no word in flight, o_READY high, waiting for a handshake
// ST_SHIFT | presenting bits; o_EN low only while a hold is in effect
module piso_serializer
    import piso_serializer_pkg::*;
#(
    parameter int WIDTH = 10,
    parameter int CNT_W = clog2(WIDTH + 1)
) (
    input  logic             i_CLK,
    input  logic             i_RST,
    input  logic             i_VALID,
    input  logic [WIDTH-1:0] i_DATA,
    output logic             o_READY,
    input  logic             i_HOLD,
    output logic             o_SO,
    output logic             o_EN,
    output logic             o_LAST,
    output logic             o_DONE
);

    state_t           state;
    logic [WIDTH-1:0] shreg;
    logic             accept;
    logic             advance;
    logic             tc;
    logic             pre_tc;

    // The last bit can be replaced by a new word's bit 0 only if it is
    // actually being consumed this cycle, hence the o_EN and i_HOLD terms.
    assign o_READY = !i_RST &&
                     ((state == ST_IDLE) ||
                      ((state == ST_SHIFT) && tc && o_EN && !i_HOLD));
    assign accept  = i_VALID && o_READY;
    assign advance = (state == ST_SHIFT) && !i_HOLD && !tc;

    bit_counter #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_bit_counter (
        .clk    (i_CLK),
        .rst    (i_RST),
        .clear  (accept),
        .inc    (advance),
        .tc     (tc),
        .pre_tc (pre_tc)
    );

    always_ff @(posedge i_CLK) begin
        if (i_RST) begin
            state  <= ST_IDLE;
            shreg  <= '0;
            o_SO   <= 1'b0;
            o_EN   <= 1'b0;
            o_LAST <= 1'b0;
            o_DONE <= 1'b0;
        end else begin
            o_DONE <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        state  <= ST_SHIFT;
                        shreg  <= i_DATA >> 1;
                        o_SO   <= i_DATA[0];
                        o_EN   <= 1'b1;
                        o_LAST <= 1'b0;
                    end
                end
                ST_SHIFT: begin
                    if (i_HOLD) begin
                        o_EN   <= 1'b0;
                        o_LAST <= 1'b0;
                    end else if (tc) begin
                        o_DONE <= 1'b1;
                        if (accept) begin
                            shreg  <= i_DATA >> 1;
                            o_SO   <= i_DATA[0];
                            o_EN   <= 1'b1;
                            o_LAST <= 1'b0;
                        end else begin
                            state  <= ST_IDLE;
                            o_EN   <= 1'b0;
                            o_LAST <= 1'b0;
                        end
                    end else begin
                        shreg  <= shreg >> 1;
                        o_SO   <= shreg[0];
                        o_EN   <= 1'b1;
                        o_LAST <= pre_tc;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    o_EN  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/piso_serializer.md
# piso_serializer

Parallel-in, serial-out serializer that converts a WIDTH-bit word into a bit stream with a per-bit enable strobe. It is the transmit-side counterpart of the serial-input, parallel-output shift_register in the stereo-vision datapath. It drives that register's i_SI/i_EN pair LSB-first, so after WIDTH strobes the receiver's o_DATA equals the original word. A valid/ready handshake on the parallel side lets an upstream producer stream words back-to-back.

## Interface
- WIDTH, 10, word length in bits; legal range ≥ 2
- CNT_W, $clog2(WIDTH+1), bit-counter width (derived; do not override)

- i_CLK  input  1  clock, all state on rising edge
- i_RST  input  1  reset, synchronous, active-high
- i_VALID  input  1  upstream word available on i_DATA
- i_DATA  input  WIDTH  parallel word; sampled only on handshake
- o_READY  output  1  block can accept a word this cycle
- i_HOLD  input  1  downstream pause; freezes bit progression
- o_SO  output  1  serial data, LSB first; connects to receiver i_SI
- o_EN  output  1  bit strobe; receiver shifts o_SO in on this cycle; connects to receiver i_EN
- o_LAST  output  1  high with o_EN on bit WIDTH-1
- o_DONE  output  1  one-cycle pulse when the receiver word is complete

## Operation
- FSM with two states:
  - IDLE: o_READY=1. On i_VALID & o_READY, capture i_DATA into the shift register, clear bit counter cnt, go to SHIFT.
  - SHIFT: emit one bit per unheld cycle.
- Bit k of the captured word appears on o_SO in the k-th o_EN=1 cycle after capture (k = 0..WIDTH-1). o_EN=1 means the bit is consumed that cycle.
- i_HOLD sampled high at an edge while in SHIFT:
  - next cycle has o_EN=0;
  - o_SO, cnt and the shift register are unchanged;
  - progression resumes the cycle after i_HOLD is low.
- In SHIFT, o_READY = (cnt == WIDTH-1) & o_EN & !i_HOLD, combinational on i_HOLD.
  - Accepting a word in that cycle gives a seamless stream: the next cycle carries bit 0 of the new word with o_EN=1. No idle gap.
- Completing bit WIDTH-1 without a new accept returns the FSM to IDLE with o_EN=0.
- o_DONE pulses in the cycle after the o_LAST cycle, whether or not a new word started.
- i_VALID in SHIFT outside the o_READY window: ignored; upstream must hold i_VALID.
- i_HOLD in IDLE: no effect. i_DATA changes after capture: no effect.
- cnt range is 0..WIDTH-1. No wrap beyond WIDTH-1; at WIDTH-1 it reloads to 0 on accept or stops in IDLE.

## Timing
- Reset values: o_SO=0, o_EN=0, o_LAST=0, o_DONE=0, o_READY=0 during the reset cycle. State=IDLE, cnt=0, shift register=0. o_READY=1 the first cycle after i_RST deasserts.
- Reset mid-word: the word is abandoned. o_EN and o_DONE drop the cycle after the reset edge, with no pulse for the partial word.
- Latency: handshake at edge t gives bit 0 with o_EN=1 in cycle t+1. With no holds:
  - o_LAST in cycle t+WIDTH;
  - o_DONE in cycle t+WIDTH+1.
- Each cycle of hold adds exactly one cycle to these figures.
- All outputs except o_READY are registered.

## Structure
- Shared package/header holds:
  - FSM state encodings (IDLE, SHIFT);
  - a clog2 constant function reused by the serial-link blocks.
- One natural sub-module, bit_counter, provides:
  - inputs: clear, increment enable;
  - output: terminal-count flag at WIDTH-1;
  - parameterised by WIDTH.
- Shift register and FSM live in the top module.

## Test plan
- **Single word:** WIDTH=10, i_DATA=10'h2B5, one handshake, i_HOLD=0.
  - o_SO sequence 1,0,1,0,1,1,0,1,0,1 over 10 o_EN cycles.
  - o_LAST on the 10th.
  - o_DONE the next cycle.
  - Attached shift_register o_DATA=10'h2B5.
- **Back-to-back:** i_VALID held high with words 10'h3FF then 10'h001.
  - 20 consecutive o_EN=1 cycles.
  - o_READY high only in the two o_LAST-aligned windows plus the initial IDLE.
  - Receiver shows 10'h3FF then 10'h001.
- **Hold:** i_HOLD high for 3 cycles after bit 4 of 10'h155.
  - o_EN=0 for 3 cycles, o_SO steady.
  - Bit 5 follows.
  - o_DONE delayed by exactly 3 cycles.
  - Word intact.
- **Hold on last bit:** i_HOLD=1 in the o_LAST cycle while i_VALID=1.
  - o_READY=0 that cycle, so no accept.
  - Accept occurs in IDLE afterwards.
- **Reset mid-word:** i_RST after bit 6.
  - Next cycle all outputs 0, no o_DONE.
  - Then o_READY=1.
  - A new word 10'h0AA serializes correctly.
- **Protocol noise:** i_DATA toggled and i_VALID pulsed during SHIFT outside the o_READY window.
  - Stream unaffected; no extra words captured.
